// File: rtl/bin_bcd_display_if.sv
// Request/result bundle for the binary-to-BCD seven-segment converter.
// The requester drives the master side, the converter sits on the slave side.
interface bin_bcd_display_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
);
  logic                start;
  logic [WIDTH-1:0]    value;
  logic                blank_lz;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7*DIGITS-1:0] hex;

  modport master (output start, value, blank_lz, input busy, done, overflow, hex);
  modport slave  (input start, value, blank_lz, output busy, done, overflow, hex);
endinterface

// File: rtl/bin_bcd_display.sv
// Sequential double-dabble converter from an unsigned binary value to
// active-low seven-segment digits, with overflow dashes and zero blanking.
module bin_bcd_display #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input logic               clock,
  input logic               reset,
  bin_bcd_display_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q, ovf_d;
  logic                blank_q;
  logic                busy_q, done_q, overflow_q;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic [BW:0]         adj;
  logic                nz_seen;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // One dabble step; the extra top bit of adj catches a carry out of the
  // accumulator, and adj[BW-1] is the bit about to be shifted out.
  always_comb begin
    adj = {1'b0, bcd_q};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj = adj + ((BW+1)'(3) << (4*i));
    end
    bcd_d  = {adj[BW-2:0], opnd_q[WIDTH-1]};
    opnd_d = opnd_q << 1;
    ovf_d  = ovf_q | adj[BW] | adj[BW-1];
  end

  always_comb begin
    hex_d   = '1;
    nz_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) nz_seen = 1'b1;
      if (ovf_q)                            hex_d[7*i +: 7] = 7'b0111111;
      else if (blank_q && !nz_seen && i != 0) hex_d[7*i +: 7] = 7'b1111111;
      else                                   hex_d[7*i +: 7] = seg(bcd_q[4*i +: 4]);
    end
  end

  // SHIFT spends WIDTH cycles dabbling and one more cycle publishing the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      hex_q      <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            bcd_q   <= '0;
            opnd_q  <= bus.value;
            blank_q <= bus.blank_lz;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            bcd_q  <= bcd_d;
            opnd_q <= opnd_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_q - CW'(1);
          end else begin
            hex_q      <= hex_d;
            overflow_q <= ovf_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.hex      = hex_q;
endmodule

// File: tb/tb_bin_bcd_display.sv
// Self-checking bench for bin_bcd_display: a 6-bit and a 7-bit instance share
// stimulus and are compared every cycle against a latency/arithmetic model.
module tb_bin_bcd_display;
  localparam int D  = 2;
  localparam int WA = 6;
  localparam int WB = 7;
  localparam int HW = 7 * D;

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] value   = '0;
  logic        blankLz = 1'b0;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  bin_bcd_display_if #(.WIDTH(WA), .DIGITS(D)) busA ();
  bin_bcd_display_if #(.WIDTH(WB), .DIGITS(D)) busB ();

  assign busA.start    = start;
  assign busA.value    = value[WA-1:0];
  assign busA.blank_lz = blankLz;
  assign busB.start    = start;
  assign busB.value    = value[WB-1:0];
  assign busB.blank_lz = blankLz;

  bin_bcd_display #(.WIDTH(WA), .DIGITS(D)) dutA (.clock(clock), .reset(reset), .bus(busA));
  bin_bcd_display #(.WIDTH(WB), .DIGITS(D)) dutB (.clock(clock), .reset(reset), .bus(busB));

  always #5 clock = ~clock;

  // Display expected for a value: plain decimal arithmetic, dashes past the
  // digit range, blanking of digits above the leading nonzero one.
  function automatic logic [HW-1:0] expHexOf(input int unsigned v, input bit bl);
    logic [HW-1:0] h;
    int unsigned   p;
    int unsigned   lim;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    h = '1;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (v >= lim)                   h[7*i +: 7] = DASH;
      else if (bl && i > 0 && v < p)  h[7*i +: 7] = BLANK;
      else                            h[7*i +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    else passes++;
  endtask

  // Model state per instance (0 = 6-bit, 1 = 7-bit), advanced once per edge.
  int            widthOf  [2] = '{WA, WB};
  bit            active   [2] = '{1'b0, 1'b0};
  int            doneEdge [2] = '{0, 0};
  logic [HW-1:0] pendHex  [2];
  bit            pendOvf  [2] = '{1'b0, 1'b0};
  logic [HW-1:0] expHex   [2];
  bit            expOvf   [2] = '{1'b0, 1'b0};
  bit            expBusy  [2] = '{1'b0, 1'b0};
  bit            expDone  [2] = '{1'b0, 1'b0};

  // Conversion accepted at edge k publishes at edge k+W+1; a new start is
  // only accepted when no conversion is outstanding (idle or the done cycle).
  always @(posedge clock) begin
    int unsigned v;
    cycle = cycle + 1;
    for (int j = 0; j < 2; j++) begin
      expDone[j] = 1'b0;
      if (reset) begin
        active[j]  = 1'b0;
        expBusy[j] = 1'b0;
        expHex[j]  = '1;
        expOvf[j]  = 1'b0;
      end else if (active[j] && cycle == doneEdge[j]) begin
        active[j]  = 1'b0;
        expBusy[j] = 1'b0;
        expDone[j] = 1'b1;
        expHex[j]  = pendHex[j];
        expOvf[j]  = pendOvf[j];
      end else if (!active[j] && start) begin
        v           = value & ((32'd1 << widthOf[j]) - 32'd1);
        active[j]   = 1'b1;
        expBusy[j]  = 1'b1;
        doneEdge[j] = cycle + widthOf[j] + 1;
        pendOvf[j]  = (v >= 100);
        pendHex[j]  = expHexOf(v, blankLz);
      end
    end
  end

  // Outputs are registered, so every cycle after the first edge is checked.
  always @(posedge clock) begin
    #1;
    if (cycle > 0) begin
      checkOutput("busyA", 32'(busA.busy), 32'(expBusy[0]));
      checkOutput("doneA", 32'(busA.done), 32'(expDone[0]));
      checkOutput("ovfA",  32'(busA.overflow), 32'(expOvf[0]));
      checkOutput("hexA",  32'(busA.hex), 32'(expHex[0]));
      checkOutput("busyB", 32'(busB.busy), 32'(expBusy[1]));
      checkOutput("doneB", 32'(busB.done), 32'(expDone[1]));
      checkOutput("ovfB",  32'(busB.overflow), 32'(expOvf[1]));
      checkOutput("hexB",  32'(busB.hex), 32'(expHex[1]));
    end
  end

  // Pulse start for one cycle and measure cycles from the capture edge to done.
  task automatic applyStimulus(input logic [31:0] v, input bit bl, output int latA, output int latB);
    @(negedge clock);
    start = 1'b1; value = v; blankLz = bl;
    @(negedge clock);
    start = 1'b0; value = $urandom; blankLz = ~bl;
    latA = -1;
    latB = -1;
    for (int n = 1; n <= 30 && (latA < 0 || latB < 0); n++) begin
      @(posedge clock); #1;
      if (busA.done && latA < 0) latA = n;
      if (busB.done && latB < 0) latB = n;
    end
  endtask

  task automatic waitDoneA(output int n);
    n = -1;
    for (int c = 1; c <= 30 && n < 0; c++) begin
      @(posedge clock); #1;
      if (busA.done) n = c;
    end
  endtask

  initial begin
    int latA, latB, n, pulses;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetHexA",  32'(busA.hex), 32'h3fff);
    checkOutput("resetBusyA", 32'(busA.busy), 32'd0);
    checkOutput("resetOvfB",  32'(busB.overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(32'd42, 1'b0, latA, latB);
    checkOutput("lat42A", 32'(latA), 32'd7);
    checkOutput("lat42B", 32'(latB), 32'd8);
    checkOutput("hex42A", 32'(busA.hex), {18'd0, 7'b0011001, 7'b0100100});
    checkOutput("ovf42A", 32'(busA.overflow), 32'd0);

    applyStimulus(32'd63, 1'b0, latA, latB);
    checkOutput("hex63A", 32'(busA.hex), {18'd0, 7'b0000010, 7'b0110000});

    applyStimulus(32'd5, 1'b1, latA, latB);
    checkOutput("hex5blankA", 32'(busA.hex), {18'd0, 7'b1111111, 7'b0010010});

    applyStimulus(32'd0, 1'b1, latA, latB);
    checkOutput("lat0A", 32'(latA), 32'd7);
    checkOutput("hex0A", 32'(busA.hex), {18'd0, 7'b1111111, 7'b1000000});

    applyStimulus(32'd100, 1'b0, latA, latB);
    checkOutput("ovf100B", 32'(busB.overflow), 32'd1);
    checkOutput("hex100B", 32'(busB.hex), {18'd0, 7'b0111111, 7'b0111111});

    applyStimulus(32'd99, 1'b0, latA, latB);
    checkOutput("ovf99B", 32'(busB.overflow), 32'd0);
    checkOutput("hex99B", 32'(busB.hex), {18'd0, 7'b0010000, 7'b0010000});

    // Start held high: 12 is captured, the change to 34 waits for the next capture.
    @(negedge clock);
    start = 1'b1; value = 32'd12; blankLz = 1'b0;
    @(negedge clock);
    value = 32'd34;
    waitDoneA(n);
    checkOutput("b2bFirstDone", 32'(n > 0), 32'd1);
    checkOutput("b2bHex12A", 32'(busA.hex), {18'd0, 7'b1111001, 7'b0100100});
    waitDoneA(n);
    checkOutput("b2bSecondDone", 32'(n > 0), 32'd1);
    checkOutput("b2bHex34A", 32'(busA.hex), {18'd0, 7'b0110000, 7'b0011001});
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);

    // Reset three cycles into a conversion must abort it silently.
    start = 1'b1; value = 32'd50; blankLz = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abortBusyA", 32'(busA.busy), 32'd0);
    checkOutput("abortHexA",  32'(busA.hex), 32'h3fff);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (busA.done || busB.done) pulses++;
    end
    checkOutput("abortNoDone", 32'(pulses), 32'd0);
    applyStimulus(32'd9, 1'b1, latA, latB);
    checkOutput("hex9blankA", 32'(busA.hex), {18'd0, 7'b1111111, 7'b0010000});
    checkOutput("lat9A", 32'(latA), 32'd7);

    // Random traffic: inputs wiggle every cycle, the model decides what matters.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      start   = ($urandom_range(0, 3) == 0);
      value   = $urandom_range(0, 127);
      blankLz = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 79) == 0);
    end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
